// File: rtl/text_scan_if.sv
// Display-side bundle of the text scan generator: memory address out, ascii in,
// font-ROM address and video timing out, plus the pixel-rate enable.
interface text_scan_if;
  logic        pix_en;
  logic [6:0]  disp_x;
  logic [13:0] disp_y;
  logic [7:0]  ascii;
  logic [11:0] font_addr;
  logic [2:0]  font_col;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  // Generator side.
  modport master (
    input  pix_en, ascii,
    output disp_x, disp_y, font_addr, font_col, de, hsync, vsync, frame_start
  );

  // Display memory / video sink side.
  modport slave (
    output pix_en, ascii,
    input  disp_x, disp_y, font_addr, font_col, de, hsync, vsync, frame_start
  );
endinterface

// File: rtl/text_scan_gen.sv
// 80x30 text-mode scan generator: VGA timing counters, display-memory symbol address,
// and one registered stage producing font-ROM address, pixel column and sync/de.
module text_scan_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input logic         clk,
  input logic         resetn,
  text_scan_if.master bus
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  // There is no valid/ready pair here: pix_en qualifies every cycle, and all state,
  // counters and output stage alike, advances only on clocks where pix_en is 1.
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;

  logic [7:0]  ascii_q, ascii_d;
  logic [3:0]  char_row_q;
  logic [2:0]  font_col_q;
  logic        de_q;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  logic        vis0;
  logic [13:0] row_ext;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (bus.pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Stage 0: symbol address straight from the counters; row*80 = row*64 + row*16.
  always_comb begin
    vis0    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    row_ext = {9'd0, v_cnt_q[8:4]};
  end

  assign bus.disp_x = vis0 ? h_cnt_q[9:3] : 7'd0;
  assign bus.disp_y = vis0 ? ((row_ext << 6) + (row_ext << 4)) : 14'd0;

  always_comb begin
    ascii_d       = vis0 ? bus.ascii : 8'd0;
    hsync_d       = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vsync_d       = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      ascii_q       <= '0;
      char_row_q    <= '0;
      font_col_q    <= '0;
      de_q          <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else if (bus.pix_en) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      ascii_q       <= ascii_d;
      char_row_q    <= v_cnt_q[3:0];
      font_col_q    <= h_cnt_q[2:0];
      de_q          <= vis0;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.font_addr   = {ascii_q, char_row_q};
  assign bus.font_col    = font_col_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_text_scan_gen.sv
// Bench for text_scan_gen: a full 640x480 instance and a shrunken-geometry instance
// share one random stimulus stream and are checked against an arithmetic scan model.
module tb_text_scan_gen;

  typedef struct packed {
    logic [6:0]  dx;
    logic [13:0] dy;
    logic [11:0] fa;
    logic [2:0]  fc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  int clk_cnt = 0;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  logic       pix_en = 1'b0;
  logic [7:0] ascii  = 8'd0;
  int         mode   = 0;

  text_scan_if bus_f ();
  text_scan_if bus_s ();
  assign bus_f.pix_en = pix_en;
  assign bus_f.ascii  = ascii;
  assign bus_s.pix_en = pix_en;
  assign bus_s.ascii  = ascii;

  text_scan_gen u_full (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_f)
  );

  text_scan_gen #(
    .H_VIS(104), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_VIS(88),  .V_FP(4), .V_SYNC(2),  .V_BP(3)
  ) u_small (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_s)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
  endtask

  // Enabled-edge count since reset, and the ascii sampled at the last enabled edge.
  int         n = 0;
  logic [7:0] a_prev = 8'd0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n      <= 0;
      a_prev <= 8'd0;
    end else if (pix_en) begin
      n      <= n + 1;
      a_prev <= ascii;
    end
  end

  // Outputs after nn enabled cycles: stage 0 shows position nn, stage 1 position nn-1.
  function automatic out_t model(input int nn, input int hv, input int hf, input int hw,
                                 input int hb, input int vv, input int vf, input int vw,
                                 input int vb, input logic [7:0] ap);
    out_t o;
    int ht, vt, h, v, ph, pv;
    bit vis, pvis;
    ht  = hv + hf + hw + hb;
    vt  = vv + vf + vw + vb;
    h   = nn % ht;
    v   = (nn / ht) % vt;
    vis = (h < hv) && (v < vv);
    o.dx = vis ? 7'(h / 8) : 7'd0;
    o.dy = vis ? 14'((v / 16) * 80) : 14'd0;
    if (nn == 0) begin
      o.fa = 12'd0; o.fc = 3'd0; o.de = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.fs = 1'b0;
    end else begin
      ph   = (nn - 1) % ht;
      pv   = ((nn - 1) / ht) % vt;
      pvis = (ph < hv) && (pv < vv);
      o.fa = {pvis ? ap : 8'h00, 4'(pv % 16)};
      o.fc = 3'(ph % 8);
      o.de = pvis;
      o.hs = !((ph >= hv + hf) && (ph < hv + hf + hw));
      o.vs = !((pv >= vv + vf) && (pv < vv + vf + vw));
      o.fs = (ph == 0) && (pv == 0);
    end
    return o;
  endfunction

  // ---------------- compare process ----------------
  out_t ef, es, af, as_o;
  int   last_n = 0, hs_lo = 0, de_hi = 0, vs_lo = 0;
  logic prev_fs_s = 1'b0, prev_hs_f = 1'b1;
  int   fall_cnt = 0, fall_t0 = 0;
  logic lp_done = 1'b0;

  always @(negedge clk) begin
    ef   = model(n, 640, 16, 96, 48, 480, 10, 2, 33, a_prev);
    es   = model(n, 104, 8, 16, 8, 88, 4, 2, 3, a_prev);
    af   = {bus_f.disp_x, bus_f.disp_y, bus_f.font_addr, bus_f.font_col,
            bus_f.de, bus_f.hsync, bus_f.vsync, bus_f.frame_start};
    as_o = {bus_s.disp_x, bus_s.disp_y, bus_s.font_addr, bus_s.font_col,
            bus_s.de, bus_s.hsync, bus_s.vsync, bus_s.frame_start};
    check("out_full", 64'(af), 64'(ef));
    check("out_small", 64'(as_o), 64'(es));

    if (!resetn) begin
      last_n = 0; hs_lo = 0; de_hi = 0; vs_lo = 0;
    end else if (n != last_n) begin
      last_n = n;
      if (n >= 1 && n <= 800) begin
        if (!bus_f.hsync) hs_lo++;
        if (bus_f.de) de_hi++;
      end
      if (n >= 1 && n <= 13192 && !bus_s.vsync) vs_lo++;
      if (n == 801) begin
        check("hsync_low_cycles", 64'(hs_lo), 64'd96);
        check("de_high_cycles", 64'(de_hi), 64'd640);
      end
      if (n == 13193) check("vsync_low_cycles_small", 64'(vs_lo), 64'd272);
    end

    if (resetn) begin
      if (n == 392) begin
        check("blank_s_disp_x", 64'(bus_s.disp_x), 64'd0);
        check("blank_s_disp_y", 64'(bus_s.disp_y), 64'd0);
      end
      if (n == 393) check("blank_s_font_hi", 64'(bus_s.font_addr[11:4]), 64'd0);
      if (n == 1500) begin
        check("blank_f_disp_x", 64'(bus_f.disp_x), 64'd0);
        check("blank_f_disp_y", 64'(bus_f.disp_y), 64'd0);
      end
      if (n == 1501) check("blank_f_font_hi", 64'(bus_f.font_addr[11:4]), 64'd0);
      if (n == 11388) begin
        check("addr_s_disp_x", 64'(bus_s.disp_x), 64'd12);
        check("addr_s_disp_y", 64'(bus_s.disp_y), 64'd400);
      end
      if (n == 11389) begin
        check("addr_s_font_addr", 64'(bus_s.font_addr), 64'h413);
        check("addr_s_font_col", 64'(bus_s.font_col), 64'd4);
        check("addr_s_de", 64'(bus_s.de), 64'd1);
      end
      if (n == 12900) begin
        check("addr_f_disp_x", 64'(bus_f.disp_x), 64'd12);
        check("addr_f_disp_y", 64'(bus_f.disp_y), 64'd80);
      end
      if (n == 12901) begin
        check("addr_f_font_addr", 64'(bus_f.font_addr), 64'h410);
        check("addr_f_font_col", 64'(bus_f.font_col), 64'd4);
        check("addr_f_de", 64'(bus_f.de), 64'd1);
      end
    end

    if (resetn && !prev_fs_s && bus_s.frame_start) begin
      if (exp_q.size() == 0) check("frame_start_extra", 64'(n), 64'hFFFF_FFFF);
      else check("frame_start_at", 64'(n), 64'(exp_q.pop_front()));
    end
    prev_fs_s = bus_s.frame_start;

    if (mode == 1 && prev_hs_f && !bus_f.hsync) begin
      fall_cnt++;
      if (fall_cnt == 1) fall_t0 = clk_cnt;
      else if (fall_cnt == 2) begin
        check("line_period_clk", 64'(clk_cnt - fall_t0), 64'd1600);
        lp_done = 1'b1;
      end
    end
    prev_hs_f = bus_f.hsync;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    case (mode)
      0:       pix_en = ($urandom_range(0, 3) != 0);
      1:       pix_en = ~pix_en;
      default: pix_en = 1'b1;
    endcase
    if (n == 392 || n == 1500)        ascii = 8'hFF;
    else if (n == 11388 || n == 12900) ascii = 8'h41;
    else                               ascii = 8'($urandom_range(0, 255));
  endtask

  task automatic load_frame_queue();
    exp_q.delete();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd13193);
    exp_q.push_back(32'd26385);
  endtask

  initial begin
    #1 resetn = 1'b0;
    load_frame_queue();
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (200) step();

    // Asynchronous reset mid-line, checked before any clock edge.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst_f_de", 64'(bus_f.de), 64'd0);
    check("rst_f_hsync", 64'(bus_f.hsync), 64'd1);
    check("rst_f_vsync", 64'(bus_f.vsync), 64'd1);
    check("rst_f_font_addr", 64'(bus_f.font_addr), 64'd0);
    check("rst_f_disp_x", 64'(bus_f.disp_x), 64'd0);
    check("rst_f_disp_y", 64'(bus_f.disp_y), 64'd0);
    check("rst_s_frame_start", 64'(bus_s.frame_start), 64'd0);
    load_frame_queue();
    repeat (3) @(negedge clk);
    pix_en = 1'b0;
    resetn = 1'b1;

    mode = 1;
    repeat (3200) step();
    mode = 2;
    repeat (2000) step();
    mode = 0;
    while (n < 26900 && clk_cnt < 90000) step();
    @(negedge clk);

    if (n < 26900) check("run_budget", 64'(n), 64'd26900);
    check("line_period_seen", 64'(lp_done), 64'd1);
    check("frame_start_all_seen", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
